// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared ALU codes, opcode patterns, state and opclass enums for the LEGv8 multicycle controller
package legv8_pkg;

  localparam int OPCODE_W   = 11;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] OPAND  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] OPORR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] OPADD  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] OPLDUR = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] OPSTUR = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] OPSUB  = 4'b0110;

  localparam logic [OPCODE_W-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPCODE_W-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPCODE_W-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPCODE_W-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [OPCODE_W-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPCODE_W-1:0] OPC_STUR = 11'b11111000000;
  localparam logic [OPCODE_W-1:0] OPC_CBZ  = 11'b10110100000;
  localparam logic [OPCODE_W-1:0] MSK_CBZ  = 11'b11111111000;
  localparam logic [OPCODE_W-1:0] OPC_B    = 11'b00010100000;
  localparam logic [OPCODE_W-1:0] MSK_B    = 11'b11111100000;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_LD    = 4'd7,
    S_MEM_WR   = 4'd8,
    S_CBZ      = 4'd9,
    S_BR       = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    OC_NONE = 3'd0,
    OC_R    = 3'd1,
    OC_LD   = 3'd2,
    OC_ST   = 3'd3,
    OC_CBZ  = 3'd4,
    OC_B    = 3'd5
  } opclass_e;

endpackage

// File: rtl/legv8_opcode_decode.sv
// rtl/legv8_opcode_decode.sv - combinational opcode classifier: opclass, R-type ALU code and legality
module legv8_opcode_decode
  import legv8_pkg::*;
(
  input  logic [OPCODE_W-1:0]   opcode,
  output opclass_e              opclass,
  output logic [ALU_CTRL_W-1:0] r_alu_op,
  output logic                  legal
);

  always_comb begin
    opclass  = OC_NONE;
    r_alu_op = OPADD;
    legal    = 1'b1;
    case (opcode)
      OPC_ADD:  begin opclass = OC_R; r_alu_op = OPADD; end
      OPC_SUB:  begin opclass = OC_R; r_alu_op = OPSUB; end
      OPC_AND:  begin opclass = OC_R; r_alu_op = OPAND; end
      OPC_ORR:  begin opclass = OC_R; r_alu_op = OPORR; end
      OPC_LDUR: opclass = OC_LD;
      OPC_STUR: opclass = OC_ST;
      default: begin
        // CBZ and B carry register / offset bits inside the 11-bit field
        if ((opcode & MSK_CBZ) == OPC_CBZ) begin
          opclass = OC_CBZ;
        end else if ((opcode & MSK_B) == OPC_B) begin
          opclass = OC_B;
        end else begin
          legal = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// rtl/legv8_multicycle_control.sv - multicycle LEGv8 main controller: state register, latched opclass, output decode
module legv8_multicycle_control
  import legv8_pkg::*;
#(
  parameter int OPW   = 11,
  parameter int ALUCW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic [ALUCW-1:0] ALUControlInput,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             Reg2Loc,
  output logic             Illegal,
  output logic [3:0]       State
);

  state_e                  state_q, state_d;
  opclass_e                opclass_q, opclass_d;
  logic [ALUCW-1:0]        rop_q, rop_d;
  opclass_e                dec_class;
  logic [ALU_CTRL_W-1:0]   dec_rop;
  logic                    dec_legal;

  // Zero qualifies the PC load in the datapath through PCWriteCond; no state depends on it
  logic unused_zero;
  assign unused_zero = Zero;

  legv8_opcode_decode u_decode (
    .opcode   (Opcode),
    .opclass  (dec_class),
    .r_alu_op (dec_rop),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opclass_q <= OC_NONE;
      rop_q     <= OPADD;
    end else begin
      state_q   <= state_d;
      opclass_q <= opclass_d;
      rop_q     <= rop_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    opclass_d       = opclass_q;
    rop_d           = rop_q;
    ALUControlInput = OPADD;
    ALUSrcA         = 1'b0;
    ALUSrcB         = 2'b00;
    PCSource        = 2'b00;
    PCWrite         = 1'b0;
    PCWriteCond     = 1'b0;
    IRWrite         = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    IorD            = 1'b0;
    RegWrite        = 1'b0;
    MemToReg        = 1'b0;
    Reg2Loc         = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        opclass_d = dec_class;
        rop_d     = dec_rop;
        if (!dec_legal) begin
          state_d = S_TRAP;
        end else begin
          case (dec_class)
            OC_R:         state_d = S_EXEC_R;
            OC_LD, OC_ST: state_d = S_MEM_ADDR;
            OC_CBZ:       state_d = S_CBZ;
            OC_B:         state_d = S_BR;
            default:      state_d = S_TRAP;
          endcase
        end
      end
      S_EXEC_R: begin
        ALUSrcA         = 1'b1;
        ALUControlInput = rop_q;
        state_d         = S_WB_R;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA         = 1'b1;
        ALUSrcB         = 2'b10;
        ALUControlInput = (opclass_q == OC_LD) ? OPLDUR : OPSTUR;
        state_d         = (opclass_q == OC_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = S_WB_LD;
      end
      S_WB_LD: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_CBZ: begin
        Reg2Loc     = 1'b1;
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
      end
      S_BR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  assign Illegal = (state_q == S_TRAP);
  assign State   = state_q;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// tb/tb_legv8_multicycle_control.sv - scoreboard bench for the LEGv8 multicycle controller
module tb_legv8_multicycle_control;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Opcode;
  logic        Zero, MemReady;
  logic [3:0]  ALUControlInput;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic        PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, IorD;
  logic        RegWrite, MemToReg, Reg2Loc, Illegal;
  logic [3:0]  State;

  legv8_multicycle_control #(.OPW(11), .ALUCW(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .ALUControlInput(ALUControlInput), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .Reg2Loc(Reg2Loc), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4;

  typedef struct {
    int cycles; int mr; int mw; int rw; int m2r; int pcw; int pcload; int btgt;
    int pcwc; int irw; int exec_op; int addr_op; int r2l_bad; int both_mem; int rw_pcw; int ill;
  } rec_t;

  int   tests = 0;
  int   fails = 0;
  rec_t exp_q[$];
  rec_t acc;
  bit   mon_en = 0, rec_open = 0, prev_fetch = 0, cur_fetch;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int strobes();
    return int'({MemRead, MemWrite, RegWrite, PCWrite, PCWriteCond, IRWrite, Illegal});
  endfunction

  function automatic rec_t clear_rec();
    rec_t r;
    r.cycles = 0; r.mr = 0; r.mw = 0; r.rw = 0; r.m2r = 0; r.pcw = 0; r.pcload = 0; r.btgt = 0;
    r.pcwc = 0; r.irw = 0; r.exec_op = -1; r.addr_op = -1; r.r2l_bad = 0; r.both_mem = 0;
    r.rw_pcw = 0; r.ill = 0;
    return r;
  endfunction

  // Reference: what one instruction must do, from the instruction-level rules
  function automatic rec_t model(input int cls, input int sf, input int sm, input bit z,
                                 input logic [10:0] op);
    rec_t r = clear_rec();
    bit mem = (cls == C_LD) || (cls == C_ST);
    case (cls)
      C_R:     r.cycles = sf + 4;
      C_LD:    r.cycles = sf + 5 + sm;
      C_ST:    r.cycles = sf + 4 + sm;
      default: r.cycles = sf + 3;
    endcase
    r.mr     = sf + 1 + ((cls == C_LD) ? sm + 1 : 0);
    r.mw     = (cls == C_ST) ? sm + 1 : 0;
    r.rw     = (cls == C_R || cls == C_LD) ? 1 : 0;
    r.m2r    = (cls == C_LD) ? 1 : 0;
    r.pcw    = 1 + ((cls == C_B) ? 1 : 0);
    r.btgt   = (cls == C_B) ? 1 : 0;
    r.pcwc   = (cls == C_CBZ) ? 1 : 0;
    r.pcload = r.pcw + ((cls == C_CBZ && z) ? 1 : 0);
    r.irw    = 1;
    if (cls == C_R) begin
      if (op == 11'b10001011000)      r.exec_op = 2;
      else if (op == 11'b11001011000) r.exec_op = 6;
      else if (op == 11'b10001010000) r.exec_op = 0;
      else                            r.exec_op = 1;
    end
    if (mem) r.addr_op = (cls == C_LD) ? 3 : 4;
    return r;
  endfunction

  task automatic close_rec();
    rec_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_underflow: got instruction with %0d cycles, expected none", acc.cycles);
      return;
    end
    tests--;
    e = exp_q.pop_front();
    chk("cycles", acc.cycles, e.cycles);
    chk("memread_cycles", acc.mr, e.mr);
    chk("memwrite_cycles", acc.mw, e.mw);
    chk("regwrite_pulses", acc.rw, e.rw);
    chk("regwrite_memtoreg", acc.m2r, e.m2r);
    chk("pcwrite_pulses", acc.pcw, e.pcw);
    chk("pc_loads", acc.pcload, e.pcload);
    chk("branch_target", acc.btgt, e.btgt);
    chk("pcwritecond", acc.pcwc, e.pcwc);
    chk("irwrite", acc.irw, e.irw);
    chk("exec_alu_op", acc.exec_op, e.exec_op);
    chk("addr_alu_op", acc.addr_op, e.addr_op);
    chk("memwrite_reg2loc", acc.r2l_bad, e.r2l_bad);
    chk("memread_and_memwrite", acc.both_mem, e.both_mem);
    chk("regwrite_and_pcwrite", acc.rw_pcw, e.rw_pcw);
    chk("illegal", acc.ill, e.ill);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cur_fetch = MemRead && !IorD;
      if (cur_fetch && !prev_fetch) begin
        if (rec_open) close_rec();
        acc = clear_rec();
        rec_open = 1;
      end
      if (rec_open) begin
        acc.cycles += 1;
        if (MemRead) acc.mr += 1;
        if (MemWrite) acc.mw += 1;
        if (RegWrite) acc.rw += 1;
        if (RegWrite && MemToReg) acc.m2r += 1;
        if (PCWrite) acc.pcw += 1;
        if (PCWrite || (PCWriteCond && Zero)) acc.pcload += 1;
        if (PCWrite && PCSource == 2'b10) acc.btgt += 1;
        if (PCWriteCond && PCSource == 2'b01) acc.pcwc += 1;
        if (IRWrite) acc.irw += 1;
        if (ALUSrcA && ALUSrcB == 2'b00 && !Reg2Loc) acc.exec_op = int'(ALUControlInput);
        if (ALUSrcA && ALUSrcB == 2'b10) acc.addr_op = int'(ALUControlInput);
        if (MemWrite && !Reg2Loc) acc.r2l_bad += 1;
        if (MemRead && MemWrite) acc.both_mem += 1;
        if (RegWrite && PCWrite) acc.rw_pcw += 1;
        if (Illegal) acc.ill += 1;
      end
      prev_fetch = cur_fetch;
    end
  end

  task automatic run_instr(input int cls, input int sf, input int sm, input bit z,
                           input logic [10:0] op, input int total);
    int rdy_m = (cls == C_LD || cls == C_ST) ? sf + 3 + sm : -1;
    for (int i = 0; i < total; i++) begin
      @(posedge clk); #1;
      MemReady = (i == sf) || (i == rdy_m);
      Opcode   = (i == sf + 1) ? op : 11'($urandom);
      Zero     = (i == sf + 2) ? z : 1'($urandom);
    end
  endtask

  initial begin
    int cls, sf, sm;
    bit z;
    logic [10:0] op;
    rec_t e;
    logic [10:0] rops [4];
    rops[0] = 11'b10001011000; rops[1] = 11'b11001011000;
    rops[2] = 11'b10001010000; rops[3] = 11'b10101010000;

    reset = 1'b1; Opcode = '0; Zero = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", int'(State), int'(S_IDLE));
    chk("reset_strobes", strobes(), 0);
    chk("reset_aluop", int'(ALUControlInput), 2);
    mon_en = 1;

    for (int n = 0; n < 40; n++) begin
      cls = (n < 5) ? n : int'($urandom_range(0, 4));
      sf  = (n < 5) ? 0 : int'($urandom_range(0, 2));
      sm  = (cls == C_LD || cls == C_ST) ? ((n == 1) ? 3 : int'($urandom_range(0, 3))) : 0;
      z   = (n == 3) ? 1'b1 : (n == 5) ? 1'b0 : 1'($urandom);
      case (cls)
        C_R:     op = (n == 0) ? rops[0] : rops[$urandom_range(0, 3)];
        C_LD:    op = 11'b11111000010;
        C_ST:    op = 11'b11111000000;
        C_CBZ:   op = {8'b10110100, 3'($urandom)};
        default: op = {6'b000101, 5'($urandom)};
      endcase
      if (n == 5) begin cls = C_CBZ; op = 11'b10110100011; sm = 0; end
      e = model(cls, sf, sm, z, op);
      exp_q.push_back(e);
      run_instr(cls, sf, sm, z, op, e.cycles);
    end
    @(posedge clk); #1 MemReady = 1'b0;
    @(negedge clk); #1 mon_en = 0;
    chk("scoreboard_drained", exp_q.size(), 0);

    // Reset while MEM_RD is stalled
    MemReady = 1'b1;
    @(posedge clk); #1 MemReady = 1'b0; Opcode = 11'b11111000010;
    @(posedge clk); #1 Opcode = 11'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrd_state", int'(State), int'(S_MEM_RD));
    chk("midrd_regwrite", int'(RegWrite), 0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("after_reset_state", int'(State), int'(S_IDLE));
    chk("after_reset_strobes", strobes(), 0);
    @(posedge clk); #1;
    chk("after_reset_fetch", int'(State), int'(S_FETCH));
    chk("after_reset_memread", int'(MemRead), 1);
    chk("after_reset_regwrite", int'(RegWrite), 0);

    // Illegal opcode traps and holds until reset
    MemReady = 1'b1;
    @(posedge clk); #1 MemReady = 1'b0; Opcode = 11'b11111111111;
    @(posedge clk); #1;
    chk("trap_state", int'(State), int'(S_TRAP));
    for (int i = 0; i < 20; i++) begin
      MemReady = 1'($urandom); Opcode = 11'($urandom); Zero = 1'($urandom);
      @(posedge clk); #1;
      chk("trap_held", int'(Illegal), 1);
      chk("trap_strobes", strobes() & 7'h7E, 0);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("trap_cleared", int'(Illegal), 0);
    chk("trap_reset_state", int'(State), int'(S_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
